// File: rtl/tm1638_pkg.sv
// TM1638 responder shared definitions.
// Command classes, data-command bit positions and FSM states.
package tm1638_pkg;

   localparam logic [1:0] CMD_DATA = 2'b01;
   localparam logic [1:0] CMD_DISP = 2'b10;
   localparam logic [1:0] CMD_ADDR = 2'b11;

   localparam int READ_BIT  = 1;
   localparam int FIXED_BIT = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_WDATA  = 3'd2,
      ST_RDATA  = 3'd3,
      ST_IGNORE = 3'd4
   } state_t;

endpackage

// File: rtl/tm1638_pin_sync.sv
// TM1638 pin synchronizer and registered edge detector.
// Edge pulses and dio_sync are mutually aligned, SYNC_STAGES+1 clk after the pin.
module tm1638_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stb_in,
   input  logic sclk_in,
   input  logic dio_in,
   output logic stb_fall,
   output logic stb_rise,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic dio_sync
);

   logic [SYNC_STAGES-1:0] r_stb_sr;
   logic [SYNC_STAGES-1:0] r_clk_sr;
   logic [SYNC_STAGES-1:0] r_dio_sr;
   logic r_stb_d;
   logic r_clk_d;
   logic r_stb_fall;
   logic r_stb_rise;
   logic r_sclk_rise;
   logic r_sclk_fall;
   logic r_dio;
   logic w_stb;
   logic w_clk;
   logic w_dio;

   assign w_stb = r_stb_sr[SYNC_STAGES-1];
   assign w_clk = r_clk_sr[SYNC_STAGES-1];
   assign w_dio = r_dio_sr[SYNC_STAGES-1];

   assign stb_fall  = r_stb_fall;
   assign stb_rise  = r_stb_rise;
   assign sclk_rise = r_sclk_rise;
   assign sclk_fall = r_sclk_fall;
   assign dio_sync  = r_dio;

   // Synchronize pins (idle-high STB/SCLK) then register edge pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stb_sr    <= '1;
         r_clk_sr    <= '1;
         r_dio_sr    <= '0;
         r_stb_d     <= 1'b1;
         r_clk_d     <= 1'b1;
         r_stb_fall  <= 1'b0;
         r_stb_rise  <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_sclk_fall <= 1'b0;
         r_dio       <= 1'b0;
      end else begin
         r_stb_sr    <= {r_stb_sr[SYNC_STAGES-2:0], stb_in};
         r_clk_sr    <= {r_clk_sr[SYNC_STAGES-2:0], sclk_in};
         r_dio_sr    <= {r_dio_sr[SYNC_STAGES-2:0], dio_in};
         r_stb_d     <= w_stb;
         r_clk_d     <= w_clk;
         r_stb_fall  <= r_stb_d & ~w_stb;
         r_stb_rise  <= ~r_stb_d & w_stb;
         r_sclk_rise <= ~r_clk_d & w_clk;
         r_sclk_fall <= r_clk_d & ~w_clk;
         r_dio       <= w_dio;
      end
   end

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 chip-side responder: decodes controller commands,
// holds display RAM and control state, returns key-scan bytes.
module tm1638_responder
   import tm1638_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int KEY_BYTES   = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tm1638_stb_in,
   input  logic                   tm1638_clk_in,
   input  logic                   tm1638_dio_in,
   output logic                   tm1638_dio_out,
   output logic                   tm1638_dio_out_en,
   input  logic [8*KEY_BYTES-1:0] keys,
   input  logic [3:0]             ram_raddr,
   output logic [7:0]             ram_rdata,
   output logic                   display_on,
   output logic [2:0]             brightness,
   output logic                   protocol_error
);

   localparam int NBITS = 8 * KEY_BYTES;
   localparam int CW    = $clog2(NBITS + 1);

   logic w_stb_fall;
   logic w_stb_rise;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_dio;
   logic w_rx;
   logic w_last;
   logic [7:0] w_byte;

   state_t           r_state;
   logic [2:0]       r_bitcnt;
   logic [7:0]       r_shift;
   logic [3:0]       r_addr;
   logic             r_fixed;
   logic             r_read;
   logic [7:0]       r_ram [16];
   logic             r_disp_on;
   logic [2:0]       r_bright;
   logic             r_err;
   logic [NBITS-1:0] r_keys;
   logic [CW-1:0]    r_rcnt;
   logic             r_dout;
   logic             r_doen;

   tm1638_pin_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .stb_in   (tm1638_stb_in),
      .sclk_in  (tm1638_clk_in),
      .dio_in   (tm1638_dio_in),
      .stb_fall (w_stb_fall),
      .stb_rise (w_stb_rise),
      .sclk_rise(w_sclk_rise),
      .sclk_fall(w_sclk_fall),
      .dio_sync (w_dio)
   );

   assign w_rx   = w_sclk_rise && (r_state != ST_IDLE)
                && (r_state != ST_RDATA);
   assign w_last = (r_bitcnt == 3'd7);
   assign w_byte = {w_dio, r_shift[7:1]};

   assign tm1638_dio_out    = r_dout;
   assign tm1638_dio_out_en = r_doen;
   assign ram_rdata         = r_ram[ram_raddr];
   assign display_on        = r_disp_on;
   assign brightness        = r_bright;
   assign protocol_error    = r_err;

   // Framing, byte assembly, command decode, RAM writes and key shift-out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_addr    <= '0;
         r_fixed   <= 1'b0;
         r_read    <= 1'b0;
         r_disp_on <= 1'b0;
         r_bright  <= '0;
         r_err     <= 1'b0;
         r_keys    <= '0;
         r_rcnt    <= '0;
         r_dout    <= 1'b0;
         r_doen    <= 1'b0;
         for (int i = 0; i < 16; i++) r_ram[i] <= '0;
      end else if (w_stb_rise) begin
         r_state  <= ST_IDLE;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_dout   <= 1'b0;
         r_doen   <= 1'b0;
      end else if (w_stb_fall) begin
         r_state  <= ST_CMD;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_rcnt   <= '0;
      end else begin
         if (w_rx) begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_shift  <= w_byte;
         end
         if (w_rx && w_last) begin
            unique case (r_state)
               ST_CMD: begin
                  case (w_byte[7:6])
                     CMD_DATA: begin
                        r_read  <= w_byte[READ_BIT];
                        r_fixed <= w_byte[FIXED_BIT];
                        r_keys  <= keys;
                        r_rcnt  <= '0;
                        r_state <= w_byte[READ_BIT] ? ST_RDATA
                                                    : ST_IGNORE;
                     end
                     CMD_ADDR: begin
                        r_addr  <= w_byte[3:0];
                        r_state <= ST_WDATA;
                     end
                     CMD_DISP: begin
                        r_disp_on <= w_byte[3];
                        r_bright  <= w_byte[2:0];
                        r_state   <= ST_IGNORE;
                     end
                     default: begin
                        r_err   <= 1'b1;
                        r_state <= ST_IGNORE;
                     end
                  endcase
               end
               ST_WDATA: begin
                  r_ram[r_addr] <= w_byte;
                  if (!r_fixed) r_addr <= r_addr + 4'd1;
               end
               default: ;
            endcase
         end
         if ((r_state == ST_RDATA) && r_read && w_sclk_fall) begin
            if (r_rcnt < CW'(NBITS)) begin
               r_dout <= r_keys[0];
               r_doen <= 1'b1;
               r_keys <= r_keys >> 1;
               r_rcnt <= r_rcnt + 1'b1;
            end else begin
               r_dout <= 1'b0;
               r_doen <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_tm1638_responder.sv
// Testbench for tm1638_responder: acts as the TM1638 controller and
// checks the responder against a transaction-level model.
module tb_tm1638_responder;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stb;
   logic        sclk;
   logic        dio;
   logic        dout;
   logic        doen;
   logic [31:0] keys;
   logic [3:0]  ram_raddr;
   logic [7:0]  ram_rdata;
   logic        disp_on;
   logic [2:0]  bright;
   logic        perr;

   logic [7:0]  m_ram [16];
   logic        m_on;
   logic [2:0]  m_br;
   logic        m_err;
   logic        m_fixed;
   logic [7:0]  txq [$];
   logic [31:0] cap;
   bit          chk_en;
   int          nvec;
   int          nerr;

   always #5 clk = ~clk;

   tm1638_responder #(
      .SYNC_STAGES(2),
      .KEY_BYTES  (4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .tm1638_stb_in    (stb),
      .tm1638_clk_in    (sclk),
      .tm1638_dio_in    (dio),
      .tm1638_dio_out   (dout),
      .tm1638_dio_out_en(doen),
      .keys             (keys),
      .ram_raddr        (ram_raddr),
      .ram_rdata        (ram_rdata),
      .display_on       (disp_on),
      .brightness       (bright),
      .protocol_error   (perr)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
      m_on    = 1'b0;
      m_br    = 3'd0;
      m_err   = 1'b0;
      m_fixed = 1'b0;
   endtask

   // Spec-level effect of one complete STB window held in txq
   task automatic m_apply();
      logic [7:0] c;
      logic [3:0] a;
      c = txq[0];
      case (c[7:6])
         2'b01: m_fixed = c[2];
         2'b10: begin
            m_on = c[3];
            m_br = c[2:0];
         end
         2'b11: begin
            a = c[3:0];
            for (int k = 1; k < txq.size(); k++) begin
               m_ram[a] = txq[k];
               if (!m_fixed) a = a + 4'd1;
            end
         end
         default: m_err = 1'b1;
      endcase
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         sclk = 1'b0;
         dio  = b[i];
         tick(HALF);
         sclk = 1'b1;
         tick(HALF);
      end
   endtask

   task automatic run_tx();
      chk_en = 0;
      stb = 1'b0;
      tick(HALF);
      foreach (txq[k]) send_bits(txq[k], 8);
      tick(HALF);
      stb = 1'b1;
      tick(HALF);
      m_apply();
      txq.delete();
      chk_en = 1;
      tick(20);
   endtask

   task automatic tx1(input logic [7:0] a);
      txq.push_back(a);
      run_tx();
   endtask

   // Read command then 33 falling edges; keys may change mid-read
   task automatic run_read(input logic [31:0] kv, input bit chg);
      chk_en = 0;
      keys = kv;
      stb = 1'b0;
      tick(HALF);
      send_bits(8'h42, 8);
      dio = 1'b1;
      cap = '0;
      for (int i = 0; i < 32; i++) begin
         sclk = 1'b0;
         tick(HALF);
         sclk = 1'b1;
         cap[i] = dout;
         chk($sformatf("rd_en bit%0d", i), doen, 1);
         if (chg && i == 11) keys = 32'hFFFF_FFFF;
         tick(HALF);
      end
      for (int b = 0; b < 4; b++)
         chk($sformatf("key_byte%0d", b), cap[8*b +: 8], kv[8*b +: 8]);
      sclk = 1'b0;
      tick(HALF);
      chk("en_after_33", doen, 0);
      chk("dout_after_33", dout, 0);
      sclk = 1'b1;
      tick(HALF);
      stb = 1'b1;
      tick(HALF);
      chk_en = 1;
      tick(20);
   endtask

   initial begin
      rst_n = 1'b0;
      stb = 1'b1;
      sclk = 1'b1;
      dio = 1'b1;
      keys = '0;
      ram_raddr = '0;
      chk_en = 0;
      nvec = 0;
      nerr = 0;
      m_reset();

      // Compare process: DUT vs model on every idle cycle
      fork
         forever begin
            @(negedge clk);
            if (chk_en) begin
               chk("display_on", disp_on, m_on);
               chk("brightness", bright, m_br);
               chk("protocol_error", perr, m_err);
               chk("idle_dio_en", doen, 0);
               chk($sformatf("ram[%0d]", ram_raddr),
                   ram_rdata, m_ram[ram_raddr]);
               ram_raddr = ram_raddr + 4'd1;
            end
         end
      join_none

      tick(3);
      chk("rst_dio_en", doen, 0);
      chk("rst_dio_out", dout, 0);
      chk("rst_perr", perr, 0);
      rst_n = 1'b1;
      tick(5);
      chk_en = 1;
      tick(20);

      tx1(8'h40);
      txq = '{8'hC0, 8'h3F, 8'h06, 8'h5B};
      run_tx();
      chk("m_ram0_lit", m_ram[0], 8'h3F);
      chk("m_ram2_lit", m_ram[2], 8'h5B);
      chk("m_ram3_lit", m_ram[3], 8'h00);

      tx1(8'h44);
      txq = '{8'hCF, 8'hAA, 8'h55};
      run_tx();
      chk("m_ram15_fixed", m_ram[15], 8'h55);
      tx1(8'h40);
      txq = '{8'hCF, 8'h11, 8'h22};
      run_tx();
      chk("m_ram15_wrap", m_ram[15], 8'h11);
      chk("m_ram0_wrap", m_ram[0], 8'h22);

      tx1(8'h8D);
      chk("disp_on_8d", disp_on, 1);
      chk("bright_8d", bright, 5);
      tx1(8'h80);
      chk("disp_on_80", disp_on, 0);
      chk("bright_80", bright, 0);

      run_read(32'h0403_0201, 1'b1);
      chk("cap_lit", cap, 32'h0403_0201);

      tx1(8'h40);
      chk_en = 0;
      stb = 1'b0;
      tick(HALF);
      send_bits(8'hC3, 8);
      send_bits(8'hFF, 5);
      stb = 1'b1;
      tick(HALF);
      chk_en = 1;
      tick(20);
      tx1(8'h8A);
      chk("abort_disp_on", disp_on, 1);
      chk("abort_bright", bright, 2);
      chk("abort_m_ram3", m_ram[3], 8'h00);

      chk_en = 0;
      keys = 32'hA5A5_5A5A;
      stb = 1'b0;
      tick(HALF);
      send_bits(8'h42, 8);
      for (int i = 0; i < 10; i++) begin
         sclk = 1'b0;
         tick(HALF);
         sclk = 1'b1;
         tick(HALF);
      end
      chk("pre_rst_en", doen, 1);
      rst_n = 1'b0;
      #2;
      chk("rst_async_en", doen, 0);
      chk("rst_async_disp", disp_on, 0);
      m_reset();
      stb = 1'b1;
      sclk = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(5);
      chk_en = 1;
      tick(20);

      txq = '{8'h20, 8'h11, 8'h22};
      run_tx();
      chk("perr_set", perr, 1);
      tx1(8'h40);
      txq = '{8'hC0, 8'h99};
      run_tx();
      chk("perr_sticky", perr, 1);
      chk("m_ram0_after_err", m_ram[0], 8'h99);

      chk_en = 0;
      tick(2);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
Device-side (chip-end) model of the TM1638 3-wire serial protocol: it answers a TM1638 controller in the same way as a real TM1638 front-panel chip. It oversamples the controller's STB/CLK/DIO with the system clock, decodes data, address and display-control commands, and holds a 16-byte display RAM plus the display-control state. For key-read transactions it drives 4 key-scan bytes back on DIO. The block is used for FPGA/ASIC loopback, emulation of the front panel, and as a synthesizable bench responder.

Parameters:
SYNC_STAGES, 2, synchronizer flops on tm1638_clk_in / tm1638_stb_in / tm1638_dio_in (minimum 2)
KEY_BYTES, 4, number of key-scan bytes returned per read command

Ports:
clk  input  1  system clock, required >= 8x the controller SCLK frequency
rst_n  input  1  asynchronous active-low reset
tm1638_stb_in  input  1  strobe from controller, active low
tm1638_clk_in  input  1  serial clock from controller
tm1638_dio_in  input  1  serial data from controller
tm1638_dio_out  output  1  serial key data to controller
tm1638_dio_out_en  output  1  DIO output enable, 1 = responder drives
keys  input  8*KEY_BYTES  key-scan image, byte 0 = bits [7:0]
ram_raddr  input  4  display RAM read address, local side
ram_rdata  output  8  display RAM data, combinational read
display_on  output  1  display-control bit 3
brightness  output  3  display-control bits [2:0]
protocol_error  output  1  sticky illegal-command flag

Behaviour:
- Reset values: RAM all 0x00, display_on 0, brightness 0, mode = write/auto-increment, address 0, dio_out 0, dio_out_en 0, protocol_error 0.
- Input handling: all three inputs pass through SYNC_STAGES flops, followed by one registered edge-detect stage.
- Transaction framing: a transaction starts on an STB falling edge. On an STB rising edge:
  - the bit counter clears and byte_idx clears;
  - any partial byte is discarded;
  - dio_out_en goes to 0 in the next clk.
- Bit sampling: while STB is low, DIO is sampled on each synchronized SCLK rising edge, LSB first. Byte 8 completes on the 8th rising edge. SCLK activity while STB is high is ignored.
- FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
  - IDLE -> CMD on STB fall.
  - First completed byte in CMD is decoded by bits [7:6]:
    - 01 = data command. Bit 1 selects read (1) or write (0); bit 2 selects fixed address (1) or auto-increment (0). The mode register persists across transactions. Read mode -> RDATA; write mode -> IGNORE until STB rises.
    - 11 = address command. address = bits [3:0] -> WDATA.
    - 10 = display control. display_on = bit 3, brightness = bits [2:0] -> IGNORE.
    - 00 = illegal. protocol_error set (sticky until reset) -> IGNORE.
  - Any state -> IDLE on STB rise.
- WDATA: each completed byte is written to RAM[address]. In auto mode address then increments mod 16 (15 wraps to 0); in fixed mode it is unchanged. Unlimited bytes are accepted.
- RDATA:
  - keys is snapshotted on the clk where the command byte completes.
  - On each subsequent SCLK falling edge the next bit is shifted out, LSB of byte 0 first. dio_out_en = 1 from the first falling edge.
  - After 8*KEY_BYTES bits, the next falling edge deasserts dio_out_en and dio_out = 0. Further clocks are ignored.
- Latency: dio_out changes SYNC_STAGES+2 clk after the pin-level SCLK fall; the controller samples on the following rise.
- Simultaneous events: an STB rise takes priority over a same-cycle SCLK edge. A RAM write and a local read of the same address return the old data in that cycle.
- Reset mid-transaction: everything returns to reset values immediately (asynchronous). After rst_n deasserts, the first STB fall starts a fresh transaction.

Decomposition:
- Package tm1638_pkg holds:
  - command-class constants: CMD_DATA = 2'b01, CMD_DISP = 2'b10, CMD_ADDR = 2'b11;
  - data-command bit positions (READ_BIT = 1, FIXED_BIT = 2);
  - the FSM state enum.
- One sub-module, tm1638_pin_sync: the parameterized synchronizer plus edge detector. It outputs stb_fall, stb_rise, sclk_rise, sclk_fall and dio_sync.

Test Plan:
- Writes, auto mode: 0x40, then 0xC0 + 0x3F,0x06,0x5B in one STB window -> ram[0..2] = 3F,06,5B, others 00.
- Writes, fixed mode and wrap: 0x44, then 0xCF + 0xAA,0x55 -> ram[15] = 0x55. Then 0x40, then 0xCF + 0x11,0x22 -> ram[15] = 0x11, ram[0] = 0x22.
- Display control: 0x8D -> display_on = 1, brightness = 5. Then 0x80 -> display_on = 0, brightness = 0.
- Key read: keys = 0x04030201, command 0x42, then 32 SCLK pulses -> controller captures bytes 01,02,03,04. dio_out_en falls on the 33rd falling edge. Changing keys mid-read does not alter the captured bytes.
- Aborts:
  - STB rises after 5 bits of a data byte -> no RAM write, and the next transaction decodes its first byte as a command;
  - rst_n pulsed mid-read -> dio_out_en = 0 immediately.
- Illegal command: byte 0x20 -> protocol_error = 1 and following bytes in the window do not change RAM. protocol_error stays 1 through later legal transactions until reset.
